axicb_burst_arbiter: RTL

// - Shares one AXI-crossbar channel (pipeline stage or slave port) between NB_REQ requesters.
// - Round-robin, burst-locked: grant is held from the first beat until the handshake of the beat with last=1.
// - Sits in front of the channel pipeline.
// - Drives the winner index so the downstream logic can route responses back to the requester.

---
 rtl/axicb_pkg.sv | 13 +
 rtl/axicb_rr_pick.sv | 44 ++++
 rtl/axicb_burst_arbiter.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/axicb_pkg.sv
// Shared types and helpers for the burst arbiter slice.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package axicb_pkg;

    typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t;

    // Index width that never collapses to zero bits for a single requester.
    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/axicb_rr_pick.sv
// Combinational round-robin picker: lowest requester at or above ptr, else lowest overall.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides when to register the pick.
module axicb_rr_pick
    import axicb_pkg::*;
#(
    parameter int NB_REQ = 4,
    parameter int ID_W   = clog2_min1(NB_REQ)
) (
    input  logic [NB_REQ-1:0] req,
    input  logic [ID_W-1:0]   ptr,
    output logic [NB_REQ-1:0] onehot,
    output logic [ID_W-1:0]   idx,
    output logic              any
);

    logic [NB_REQ-1:0] masked;
    logic [NB_REQ-1:0] sel;

    // Keep only requests at or above the priority pointer.
    always_comb begin
        masked = '0;
        for (int k = 0; k < NB_REQ; k++) begin
            masked[k] = req[k] & (k >= int'(ptr));
        end
    end

    // Masked encoder wins when it has a hit; otherwise wrap to the unmasked one.
    always_comb begin
        sel    = (|masked) ? masked : req;
        onehot = '0;
        idx    = '0;
        for (int k = NB_REQ - 1; k >= 0; k--) begin
            if (sel[k]) begin
                onehot    = '0;
                onehot[k] = 1'b1;
                idx       = ID_W'(k);
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/axicb_burst_arbiter.sv
// Round-robin, burst-locked arbiter sharing one AXI crossbar channel; optional output slice via AXICB_ARB_PIPE_EN.
// Latency: request to o_valid 1 cycle (2 with AXICB_ARB_PIPE_EN); one IDLE bubble after every burst.
// Backpressure: o_ready steers only the granted requester's i_ready; the current beat is held, never skipped.
module axicb_burst_arbiter
    import axicb_pkg::*;
#(
    parameter int NB_REQ     = 4,
    parameter int DATA_BUS_W = 8,
    parameter int ID_W       = clog2_min1(NB_REQ)
) (
    input  logic                         aclk,
    input  logic                         aresetn,
    input  logic                         srst,
    input  logic [NB_REQ-1:0]            i_valid,
    output logic [NB_REQ-1:0]            i_ready,
    input  logic [NB_REQ*DATA_BUS_W-1:0] i_data,
    input  logic [NB_REQ-1:0]            i_last,
    output logic                         o_valid,
    input  logic                         o_ready,
    output logic [DATA_BUS_W-1:0]        o_data,
    output logic                         o_last,
    output logic [ID_W-1:0]              o_id,
    output logic                         busy
);

    arb_state_t              state, state_nxt;
    logic [ID_W-1:0]         gnt, gnt_nxt;
    logic [ID_W-1:0]         ptr, ptr_nxt;
    logic [NB_REQ-1:0]       gnt_oh, gnt_oh_nxt;

    logic [NB_REQ-1:0]       pick_onehot;
    logic [ID_W-1:0]         pick_idx;
    logic                    pick_any;

    logic                    arb_valid;
    logic                    arb_ready;
    logic [DATA_BUS_W-1:0]   arb_data;
    logic                    arb_last;
    logic                    eob;

    axicb_rr_pick #(
        .NB_REQ (NB_REQ),
        .ID_W   (ID_W)
    ) u_pick (
        .req    (i_valid),
        .ptr    (ptr),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    assign busy      = (state == ARB_BUSY);
    assign arb_valid = busy & i_valid[gnt];
    assign arb_data  = i_data[int'(gnt)*DATA_BUS_W +: DATA_BUS_W];
    assign arb_last  = i_last[gnt];
    // No beat may complete in a cycle where the synchronous reset is applied.
    assign eob       = arb_valid & arb_ready & arb_last & ~srst;
    assign i_ready   = gnt_oh & {NB_REQ{busy & arb_ready & ~srst}};

    // Next-state: arbitrate in IDLE, hold the grant until the last beat handshakes.
    always_comb begin
        state_nxt  = state;
        gnt_nxt    = gnt;
        ptr_nxt    = ptr;
        gnt_oh_nxt = gnt_oh;
        case (state)
            ARB_IDLE: begin
                if (pick_any) begin
                    state_nxt  = ARB_BUSY;
                    gnt_nxt    = pick_idx;
                    gnt_oh_nxt = pick_onehot;
                end
            end
            ARB_BUSY: begin
                if (eob) begin
                    state_nxt = ARB_IDLE;
                    ptr_nxt   = (gnt == ID_W'(NB_REQ - 1)) ? '0 : gnt + 1'b1;
                end
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end

    // FSM, grant and priority-pointer registers.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state  <= ARB_IDLE;
            gnt    <= '0;
            ptr    <= '0;
            gnt_oh <= '0;
        end else if (srst) begin
            state  <= ARB_IDLE;
            gnt    <= '0;
            ptr    <= '0;
            gnt_oh <= '0;
        end else begin
            state  <= state_nxt;
            gnt    <= gnt_nxt;
            ptr    <= ptr_nxt;
            gnt_oh <= gnt_oh_nxt;
        end
    end

`ifdef AXICB_ARB_PIPE_EN
    logic                  s_vld;
    logic [DATA_BUS_W-1:0] s_dat;
    logic                  s_last;
    logic [ID_W-1:0]       s_id;

    // Slice is full only when it holds a beat the channel is refusing.
    assign arb_ready = ~(s_vld & ~o_ready);

    // Output slice: reload whenever it is not stalled, carrying the grant index along.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            s_vld  <= 1'b0;
            s_dat  <= '0;
            s_last <= 1'b0;
            s_id   <= '0;
        end else if (srst) begin
            s_vld  <= 1'b0;
            s_dat  <= '0;
            s_last <= 1'b0;
            s_id   <= '0;
        end else if (arb_ready) begin
            s_vld  <= arb_valid;
            s_dat  <= busy ? arb_data : '0;
            s_last <= busy & arb_last;
            s_id   <= busy ? gnt : '0;
        end
    end

    assign o_valid = s_vld;
    assign o_data  = s_dat;
    assign o_last  = s_last;
    assign o_id    = s_id;
`else
    assign arb_ready = o_ready;
    assign o_valid   = arb_valid & ~srst;
    assign o_data    = busy ? arb_data : '0;
    assign o_last    = busy & arb_last;
    assign o_id      = busy ? gnt : '0;
`endif

endmodule
